// File: rtl/xs3_stream_decoder.sv
// xs3_stream_decoder: accumulates a stream of XS-3 digits (MSD first) into an
// unsigned binary word and presents it with digit count and error status.
//
// state  | meaning
// -------+---------------------------------------------------------------
// ST_ACC | accepting digits, building acc/cnt/err
// ST_OUT | result registered on m_*, waiting for m_ready, input stalled
module xs3_stream_decoder #(
  parameter int NDIG  = 4,
  parameter int OUT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [3:0]       s_digit,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_err,
  output logic [3:0]       m_ndig
);

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  localparam logic [3:0] NDIG_L  = 4'(NDIG);
  localparam logic [3:0] CNT_SAT = 4'(NDIG + 1);

  state_t           state, state_nxt;
  logic [OUT_W-1:0] acc, acc_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic             err, err_nxt;
  logic             load_out;
  logic             dig_ok;
  logic [3:0]       dig_val;
  logic [OUT_W-1:0] acc_mac;

  // Registered handshake flags fall straight out of the state register.
  assign s_ready = (state == ST_ACC);
  assign m_valid = (state == ST_OUT);

  // Decode one digit and form acc*10 + d; invalid codes contribute zero.
  always_comb begin
    dig_ok  = (s_digit >= 4'h3) && (s_digit <= 4'hC);
    dig_val = dig_ok ? (s_digit - 4'd3) : 4'd0;
    acc_mac = (acc << 3) + (acc << 1) + OUT_W'(dig_val);
  end

  // Next-state logic: accumulation, saturation, sticky error, word handoff.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    err_nxt   = err;
    load_out  = 1'b0;
    case (state)
      ST_ACC: begin
        if (s_valid) begin
          if (cnt < NDIG_L) begin
            acc_nxt = acc_mac;
            cnt_nxt = cnt + 4'd1;
          end else begin
            // Extra digit: consumed but ignored, flagged and counted once.
            cnt_nxt = CNT_SAT;
            err_nxt = 1'b1;
          end
          if (!dig_ok) err_nxt = 1'b1;
          if (s_last) begin
            state_nxt = ST_OUT;
            load_out  = 1'b1;
          end
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          state_nxt = ST_ACC;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  // State and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_ACC;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  // Result registers load only on entry to ST_OUT so they hold through ST_ACC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_data <= '0;
      m_err  <= 1'b0;
      m_ndig <= '0;
    end else if (load_out) begin
      m_data <= acc_nxt;
      m_err  <= err_nxt;
      m_ndig <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_xs3_stream_decoder.sv
// Directed self-checking bench for xs3_stream_decoder (NDIG=4, OUT_W=14).
module tb_xs3_stream_decoder;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_digit;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [13:0] m_data;
  logic        m_err;
  logic [3:0]  m_ndig;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;

  xs3_stream_decoder #(.NDIG(4), .OUT_W(14)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_digit (s_digit),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_err   (m_err),
    .m_ndig  (m_ndig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted digits independently of the DUT's internal counter.
  always @(posedge clk) begin
    if (rst_n && s_valid && s_ready) n_acc++;
  end

  // Present one digit and hold it until the accepting edge has passed.
  task automatic send_digit(input logic [3:0] d, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_digit = d;
    s_last  = last;
    while (!s_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    total++; if (m_data !== 14'd0) begin bad++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL reset_m_err: got %b want 0", m_err); end
    total++; if (m_ndig !== 4'd0) begin bad++; $display("FAIL reset_m_ndig: got %0d want 0", m_ndig); end
  endtask

  task automatic test_basic();
    send_digit(4'h4, 1'b0);
    send_digit(4'h8, 1'b0);
    send_digit(4'hC, 1'b1);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL basic_m_valid: got %b want 1", m_valid); end
    total++; if (m_data !== 14'd159) begin bad++; $display("FAIL basic_m_data: got %0d want 159", m_data); end
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL basic_m_err: got %b want 0", m_err); end
    total++; if (m_ndig !== 4'd3) begin bad++; $display("FAIL basic_m_ndig: got %0d want 3", m_ndig); end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL basic_bubble: s_ready=%b want 0", s_ready); end
    @(posedge clk); #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle: m_valid=%b want 0", m_valid); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back: s_ready=%b want 1", s_ready); end
    total++; if (m_data !== 14'd159) begin bad++; $display("FAIL basic_hold: m_data=%0d want 159", m_data); end
  endtask

  task automatic test_single_and_max();
    send_digit(4'h3, 1'b1);
    total++; if (m_data !== 14'd0) begin bad++; $display("FAIL single_m_data: got %0d want 0", m_data); end
    total++; if (m_ndig !== 4'd1) begin bad++; $display("FAIL single_m_ndig: got %0d want 1", m_ndig); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL single_m_valid: got %b want 1", m_valid); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send_digit(4'hC, (i == 3));
    total++; if (m_data !== 14'd9999) begin bad++; $display("FAIL max_m_data: got %0d want 9999", m_data); end
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL max_m_err: got %b want 0", m_err); end
    total++; if (m_ndig !== 4'd4) begin bad++; $display("FAIL max_m_ndig: got %0d want 4", m_ndig); end
    @(posedge clk); #1;
  endtask

  task automatic test_invalid();
    send_digit(4'h5, 1'b0);
    send_digit(4'hF, 1'b0);
    send_digit(4'h4, 1'b1);
    total++; if (m_data !== 14'd201) begin bad++; $display("FAIL invalid_m_data: got %0d want 201", m_data); end
    total++; if (m_err !== 1'b1) begin bad++; $display("FAIL invalid_m_err: got %b want 1", m_err); end
    total++; if (m_ndig !== 4'd3) begin bad++; $display("FAIL invalid_m_ndig: got %0d want 3", m_ndig); end
    @(posedge clk); #1;
    send_digit(4'h7, 1'b1);
    total++; if (m_data !== 14'd4) begin bad++; $display("FAIL err_clear_m_data: got %0d want 4", m_data); end
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL err_clear_m_err: got %b want 0", m_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_overlength();
    int start;
    start = n_acc;
    for (int i = 0; i < 5; i++) send_digit(4'h4, (i == 4));
    total++; if (m_data !== 14'd1111) begin bad++; $display("FAIL over_m_data: got %0d want 1111", m_data); end
    total++; if (m_err !== 1'b1) begin bad++; $display("FAIL over_m_err: got %b want 1", m_err); end
    total++; if (m_ndig !== 4'd5) begin bad++; $display("FAIL over_m_ndig: got %0d want 5", m_ndig); end
    total++; if (n_acc - start !== 5) begin bad++; $display("FAIL over_consumed: got %0d want 5", n_acc - start); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int start;
    m_ready = 1'b0;
    send_digit(4'h9, 1'b1);
    start = n_acc;
    s_valid = 1'b1;
    s_digit = 4'h5;
    s_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL stall_m_valid[%0d]: got %b want 1", i, m_valid); end
      total++; if (m_data !== 14'd6) begin bad++; $display("FAIL stall_m_data[%0d]: got %0d want 6", i, m_data); end
      total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL stall_s_ready[%0d]: got %b want 0", i, s_ready); end
      @(posedge clk); #1;
    end
    total++; if (n_acc !== start) begin bad++; $display("FAIL stall_no_accept: got %0d want %0d", n_acc, start); end
    m_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL release_s_ready: got %b want 1", s_ready); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL release_m_valid: got %b want 0", m_valid); end
    total++; if (m_data !== 14'd6) begin bad++; $display("FAIL release_hold: m_data=%0d want 6", m_data); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    total++; if (n_acc !== start + 1) begin bad++; $display("FAIL pending_accept: got %0d want %0d", n_acc, start + 1); end
    total++; if (m_data !== 14'd2) begin bad++; $display("FAIL pending_m_data: got %0d want 2", m_data); end
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL pending_m_valid: got %b want 1", m_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    send_digit(4'h4, 1'b0);
    send_digit(4'h5, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_m_valid: got %b want 0", m_valid); end
    total++; if (m_data !== 14'd0) begin bad++; $display("FAIL mid_rst_m_data: got %0d want 0", m_data); end
    total++; if (m_ndig !== 4'd0) begin bad++; $display("FAIL mid_rst_m_ndig: got %0d want 0", m_ndig); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_s_ready: got %b want 1", s_ready); end
    send_digit(4'h6, 1'b1);
    total++; if (m_data !== 14'd3) begin bad++; $display("FAIL after_rst_m_data: got %0d want 3", m_data); end
    total++; if (m_ndig !== 4'd1) begin bad++; $display("FAIL after_rst_m_ndig: got %0d want 1", m_ndig); end
    total++; if (m_err !== 1'b0) begin bad++; $display("FAIL after_rst_m_err: got %b want 0", m_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_out();
    m_ready = 1'b0;
    send_digit(4'hC, 1'b1);
    total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL out_pre_m_valid: got %b want 1", m_valid); end
    total++; if (m_data !== 14'd9) begin bad++; $display("FAIL out_pre_m_data: got %0d want 9", m_data); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL out_rst_m_valid: got %b want 0", m_valid); end
    total++; if (m_data !== 14'd0) begin bad++; $display("FAIL out_rst_m_data: got %0d want 0", m_data); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL out_rst_s_ready: got %b want 1", s_ready); end
    m_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_digit = 4'h0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    test_reset();
    test_basic();
    test_single_and_max();
    test_invalid();
    test_overlength();
    test_backpressure();
    test_reset_mid();
    test_reset_in_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
